// File: rtl/data_mem_responder.sv
// Purpose: single-port byte-addressed data memory slave with a fixed-latency req/resp handshake.
// Latency: rvalid_o rises LATENCY+1 cycles after the accept edge; exactly one response per request.
// Backpressure: ready_o is high only in IDLE; one transaction is in flight at a time.
// Build option: SUBWORD_ACCESS_EN enables byte/half accesses; otherwise only aligned words are legal.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         IW       = ADDR_WIDTH - 2;
    localparam int         WORDS    = 2 ** IW;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [WORDS];

    logic          in_idle, accept, enter_resp, commit;
    logic          eff_we, eff_uns, eff_err, err_size, oob;
    logic [31:0]   eff_addr, eff_wdata, word_rd, wlane, load_val;
    logic [1:0]    eff_size;
    logic [3:0]    be;
    logic [IW-1:0] eff_idx;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && req_i;
    assign ready_o = in_idle;

    // With LATENCY=0 RESP is entered on the accept edge itself, before the
    // request registers hold anything, so the live inputs are used in IDLE.
    assign eff_we    = in_idle ? we_i       : we_q;
    assign eff_addr  = in_idle ? addr_i     : addr_q;
    assign eff_wdata = in_idle ? wdata_i    : wdata_q;
    assign eff_size  = in_idle ? size_i     : size_q;
    assign eff_uns   = in_idle ? unsigned_i : uns_q;

    assign eff_idx = eff_addr[ADDR_WIDTH-1:2];
    assign oob     = (eff_addr >> ADDR_WIDTH) != 32'd0;
    assign word_rd = mem_q[eff_idx];

`ifdef SUBWORD_ACCESS_EN
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign sel_b = word_rd[{eff_addr[1:0], 3'b000} +: 8];
    assign sel_h = eff_addr[1] ? word_rd[31:16] : word_rd[15:0];

    // Lane enables, replicated store data, extended load data and alignment check per size.
    always_comb begin
        be       = 4'b0000;
        wlane    = eff_wdata;
        load_val = word_rd;
        err_size = 1'b0;
        case (eff_size)
            2'b00: begin
                be       = 4'b0001 << eff_addr[1:0];
                wlane    = {4{eff_wdata[7:0]}};
                load_val = {{24{~eff_uns & sel_b[7]}}, sel_b};
            end
            2'b01: begin
                be       = eff_addr[1] ? 4'b1100 : 4'b0011;
                wlane    = {2{eff_wdata[15:0]}};
                load_val = {{16{~eff_uns & sel_h[15]}}, sel_h};
                err_size = eff_addr[0];
            end
            2'b10: begin
                be       = 4'b1111;
                err_size = (eff_addr[1:0] != 2'b00);
            end
            default: err_size = 1'b1;
        endcase
    end
`else
    logic unused_uns;

    // Word-only build: anything but an aligned word is an error; no lane logic.
    always_comb begin
        be       = 4'b1111;
        wlane    = eff_wdata;
        load_val = word_rd;
        err_size = (eff_size != 2'b10) || (eff_addr[1:0] != 2'b00);
    end

    assign unused_uns = eff_uns;
`endif

    assign eff_err = err_size || oob;

    // Next-state: IDLE accepts, WAIT counts down to zero, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP);
    assign commit     = enter_resp && eff_we && !eff_err;
    assign rdata_d    = (enter_resp && !eff_we && !eff_err) ? load_val : 32'd0;
    assign err_d      = enter_resp && eff_err;

    // Control, request capture and response registers; response regs are zero outside RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
            end
        end
    end

    // Backing store: byte-lane writes on the edge entering RESP; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem_q[eff_idx][8*k +: 8] <= wlane[8*k +: 8];
            end
        end
    end

    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory held in the bench.
module tb_data_mem_responder;

    localparam int AW  = 17;
    localparam int LAT = 2;

`ifdef SUBWORD_ACCESS_EN
    localparam logic [31:0] AFTER_BYTE_ST = 32'hDEAD55EF;
`else
    localparam logic [31:0] AFTER_BYTE_ST = 32'hDEADBEEF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [1:0]  size_i = 2'b10;
    logic        unsigned_i = 1'b0;
    logic        ready_o, rvalid_o, err_o;
    logic [31:0] rdata_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [int unsigned];

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .ready_o    (ready_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic mdl_err(input logic [1:0] sz, input logic [31:0] a);
        logic bad;
        bad = (64'(a) >= (64'd1 << AW));
`ifdef SUBWORD_ACCESS_EN
        if (sz == 2'b11) bad = 1'b1;
        if (sz == 2'b01 && a[0]) bad = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
`else
        if (sz != 2'b10 || a[1:0] != 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[a + 32'(i)]) << (8 * i));
        if (!un && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) mdl[a + 32'(i)] = wd[8*i +: 8];
    endtask

    // One full transaction: present at a negedge, accept, scramble inputs, time the response.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic un,
                          output logic [31:0] rd, output logic er);
        int   lat;
        logic quiet_bad;
        logic [31:0] exp_d;
        logic        exp_e;
        @(negedge clk);
        chk("rv_drop", 32'(rvalid_o), 32'd0);
        chk("rdy_idle", 32'(ready_o), 32'd1);
        we_i = we; addr_i = a; wdata_i = wd; size_i = sz; unsigned_i = un; req_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
        size_i = 2'($urandom); unsigned_i = 1'($urandom);
        lat = 1;
        quiet_bad = 1'b0;
        while (!rvalid_o && lat <= LAT + 8) begin
            if (ready_o || rdata_o != 32'd0 || err_o) quiet_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk("wait_quiet", 32'(quiet_bad), 32'd0);
        chk("latency", 32'(lat), 32'(LAT + 1));
        chk("rdy_resp", 32'(ready_o), 32'd0);
        exp_e = mdl_err(sz, a);
        exp_d = (we || exp_e) ? 32'd0 : mdl_load(a, sz, un);
        chk(we ? "st_err" : "ld_err", 32'(err_o), 32'(exp_e));
        chk(we ? "st_rdata" : "ld_rdata", rdata_o, exp_d);
        if (we && !exp_e) mdl_store(a, sz, wd);
        rd = rdata_o;
        er = err_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        sticky;
        int          n;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);

        // Fill the working region with known words
        for (int i = 0; i < 80; i++) do_req(1'b1, 32'h100 + 32'(4 * i), $urandom, 2'b10, 1'b0, rd, er);

        // Word store / load
        do_req(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, rd, er);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, rd, er);
        chk("word_ld", rd, 32'hDEADBEEF);
        chk("word_ld_err", 32'(er), 32'd0);

        // Sub-word loads
        do_req(1'b0, 32'h103, 32'd0, 2'b00, 1'b0, rd, er);
`ifdef SUBWORD_ACCESS_EN
        chk("byte_s", rd, 32'hFFFFFFDE);
`endif
        do_req(1'b0, 32'h103, 32'd0, 2'b00, 1'b1, rd, er);
`ifdef SUBWORD_ACCESS_EN
        chk("byte_u", rd, 32'h000000DE);
`endif
        do_req(1'b0, 32'h100, 32'd0, 2'b01, 1'b0, rd, er);
`ifdef SUBWORD_ACCESS_EN
        chk("half_s", rd, 32'hFFFFBEEF);
`else
        chk("half_err", 32'(er), 32'd1);
`endif

        // Byte store merges into one lane
        do_req(1'b1, 32'h101, 32'h00000055, 2'b00, 1'b0, rd, er);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, rd, er);
        chk("byte_merge", rd, AFTER_BYTE_ST);

        // Misaligned word and out-of-range address
        do_req(1'b1, 32'h102, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er);
        chk("misalign_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h100, 32'd0, 2'b10, 1'b0, rd, er);
        chk("misalign_nochg", rd, AFTER_BYTE_ST);
        do_req(1'b1, 32'h00020000, 32'h11111111, 2'b10, 1'b0, rd, er);
        chk("oob_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h0001FFFC, 32'd0, 2'b11, 1'b0, rd, er);
        chk("size11_err", 32'(er), 32'd1);

        // Reset one cycle after accepting a store
        @(negedge clk);
        we_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h12345678; size_i = 2'b10; req_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_rvalid", 32'(rvalid_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);
        if (LAT == 0) mdl_store(32'h200, 2'b10, 32'h12345678);
        @(negedge clk);
        rst = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            if (rvalid_o || !ready_o) sticky = 1'b1;
        end
        chk("abort_quiet", 32'(sticky), 32'd0);
        do_req(1'b0, 32'h200, 32'd0, 2'b10, 1'b0, rd, er);

        // Reset while the store response is on the bus
        @(negedge clk);
        we_i = 1'b1; addr_i = 32'h204; wdata_i = 32'hCAFEF00D; size_i = 2'b10; req_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        n = 1;
        while (!rvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", 32'(rvalid_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("resp_rst_rvalid", 32'(rvalid_o), 32'd0);
        mdl_store(32'h204, 2'b10, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 32'h204, 32'd0, 2'b10, 1'b0, rd, er);
        chk("resp_rst_kept", rd, 32'hCAFEF00D);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 9);
            if (n == 0)      a = 32'h00020000 + 32'($urandom_range(0, 255));
            else if (n == 1) a = $urandom | 32'h00100000;
            else             a = 32'h100 + 32'($urandom_range(0, 32'h13C));
            sz = 2'($urandom);
            w  = 1'($urandom);
            do_req(w, a, $urandom, sz, 1'($urandom), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
